// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access-size encodings,
// FSM state encoding and the default data-memory depth.
package lsu_pkg;

  localparam int LSU_MEM_WORDS_DEFAULT = 11;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_ILL  = 2'b11
  } lsu_size_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_MERGE = 1'b1
  } lsu_state_e;

  // Alignment check shared by the unit: illegal size or a sub-word
  // access that straddles its natural boundary.
  function automatic logic lsu_misaligned(logic [1:0] size, logic [1:0] off);
    logic bad;
    bad = 1'b1;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = off[0];
      SIZE_WORD: bad = |off;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Big-endian lane handling for the load/store unit. Purely combinational:
// extracts and extends the addressed byte/half of a memory word for loads,
// and builds the read-modify-write word for sub-word stores.
// Byte offset b lives in bits [31-8b:24-8b]; half with off[1]=0 in [31:16].
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] dmem_word,
  input  logic [1:0]  byte_off,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [15:0] store_lane,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [4:0]  sh;
  logic [7:0]  lane8;
  logic [15:0] lane16;

  // Lane select and extension for loads, lane replacement for stores
  always_comb begin
    sh          = 5'd0;
    lane8       = 8'd0;
    lane16      = 16'd0;
    load_data   = dmem_word;
    merged_word = dmem_word;
    case (size)
      SIZE_BYTE: begin
        // (3 - off) * 8, since offset 0 is the most significant byte
        sh          = {~byte_off, 3'b000};
        lane8       = 8'(dmem_word >> sh);
        load_data   = is_unsigned ? {24'd0, lane8} : {{24{lane8[7]}}, lane8};
        merged_word = (dmem_word & ~(32'h0000_00FF << sh)) |
                      ({24'd0, store_lane[7:0]} << sh);
      end
      SIZE_HALF: begin
        sh          = {~byte_off[1], 4'b0000};
        lane16      = 16'(dmem_word >> sh);
        load_data   = is_unsigned ? {16'd0, lane16} : {{16{lane16[15]}}, lane16};
        merged_word = (dmem_word & ~(32'h0000_FFFF << sh)) |
                      ({16'd0, store_lane} << sh);
      end
      default: begin
        load_data   = dmem_word;
        merged_word = dmem_word;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between a core request port and a single-ported,
// combinational-read word DMEM. Loads, word stores and faults complete in
// one cycle; byte/half stores read the word, merge, and write it back in a
// second (MERGE) cycle.
// Optional build macro LSU_RANGE_CHECK_EN: fault on addr[31:10]!=0 or a
// word index at or beyond MEM_WORDS. Without it those bits are ignored.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = LSU_MEM_WORDS_DEFAULT
) (
  input  logic        LSU_clk,
  input  logic        LSU_rst,
  input  logic        LSU_req_valid,
  output logic        LSU_req_ready,
  input  logic        LSU_req_write,
  input  logic [1:0]  LSU_req_size,
  input  logic        LSU_req_unsigned,
  input  logic [31:0] LSU_req_addr,
  input  logic [31:0] LSU_req_wdata,
  output logic        LSU_rsp_valid,
  output logic [31:0] LSU_rsp_rdata,
  output logic        LSU_rsp_fault,
  output logic [7:0]  LSU_dmem_address,
  output logic [31:0] LSU_dmem_wdata,
  output logic        LSU_dmem_mem_write,
  output logic        LSU_dmem_mem_read,
  input  logic [31:0] LSU_dmem_rdata
);

  lsu_state_e  state;
  logic [7:0]  merge_idx;
  logic [31:0] merge_word;

  logic [7:0]  word_idx;
  logic [1:0]  byte_off;
  logic        range_fault;
  logic        req_fault;
  logic        accept;
  logic        is_word;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign word_idx    = LSU_req_addr[9:2];
  assign byte_off    = LSU_req_addr[1:0];
  assign is_word     = (LSU_req_size == SIZE_WORD);
  assign range_fault = (LSU_req_addr[31:10] != 22'd0) ||
                       (32'(word_idx) >= 32'(MEM_WORDS));

`ifdef LSU_RANGE_CHECK_EN
  assign req_fault = lsu_misaligned(LSU_req_size, byte_off) | range_fault;
`else
  // Range result is computed but deliberately not acted on in this build;
  // out-of-range indices go to DMEM untouched.
  logic range_fault_unused;
  assign range_fault_unused = range_fault;
  assign req_fault = lsu_misaligned(LSU_req_size, byte_off);
`endif

  // Only IDLE takes requests, and nothing is taken while in reset
  assign LSU_req_ready = (state == ST_IDLE) && !LSU_rst;
  assign accept        = LSU_req_valid && LSU_req_ready;

  lsu_lane_align u_lane_align (
    .dmem_word   (LSU_dmem_rdata),
    .byte_off    (byte_off),
    .size        (LSU_req_size),
    .is_unsigned (LSU_req_unsigned),
    .store_lane  (LSU_req_wdata[15:0]),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // DMEM port drive: merge write-back wins; otherwise the accepted request
  always_comb begin
    LSU_dmem_mem_read  = 1'b0;
    LSU_dmem_mem_write = 1'b0;
    LSU_dmem_address   = 8'd0;
    LSU_dmem_wdata     = 32'd0;
    if (state == ST_MERGE) begin
      // Reset during MERGE aborts the write-back
      if (!LSU_rst) begin
        LSU_dmem_mem_write = 1'b1;
        LSU_dmem_address   = merge_idx;
        LSU_dmem_wdata     = merge_word;
      end
    end else if (accept && !req_fault) begin
      LSU_dmem_address = word_idx;
      if (LSU_req_write && is_word) begin
        LSU_dmem_mem_write = 1'b1;
        LSU_dmem_wdata     = LSU_req_wdata;
      end else begin
        // Loads and the read half of a sub-word read-modify-write
        LSU_dmem_mem_read = 1'b1;
      end
    end
  end

  // FSM, merge capture and registered response
  always_ff @(posedge LSU_clk) begin
    if (LSU_rst) begin
      state         <= ST_IDLE;
      merge_idx     <= 8'd0;
      merge_word    <= 32'd0;
      LSU_rsp_valid <= 1'b0;
      LSU_rsp_rdata <= 32'd0;
      LSU_rsp_fault <= 1'b0;
    end else begin
      LSU_rsp_valid <= 1'b0;
      LSU_rsp_rdata <= 32'd0;
      LSU_rsp_fault <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (req_fault) begin
              LSU_rsp_valid <= 1'b1;
              LSU_rsp_fault <= 1'b1;
            end else if (!LSU_req_write) begin
              LSU_rsp_valid <= 1'b1;
              LSU_rsp_rdata <= load_data;
            end else if (is_word) begin
              LSU_rsp_valid <= 1'b1;
            end else begin
              merge_idx  <= word_idx;
              merge_word <= merged_word;
              state      <= ST_MERGE;
            end
          end
        end
        ST_MERGE: begin
          LSU_rsp_valid <= 1'b1;
          state         <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// requests against a byte-array reference model of big-endian memory.
module tb_load_store_unit;

  logic        LSU_clk = 1'b0;
  logic        LSU_rst;
  logic        LSU_req_valid;
  logic        LSU_req_ready;
  logic        LSU_req_write;
  logic [1:0]  LSU_req_size;
  logic        LSU_req_unsigned;
  logic [31:0] LSU_req_addr;
  logic [31:0] LSU_req_wdata;
  logic        LSU_rsp_valid;
  logic [31:0] LSU_rsp_rdata;
  logic        LSU_rsp_fault;
  logic [7:0]  LSU_dmem_address;
  logic [31:0] LSU_dmem_wdata;
  logic        LSU_dmem_mem_write;
  logic        LSU_dmem_mem_read;
  logic [31:0] LSU_dmem_rdata;

  logic [31:0] dmem [256];
  logic [31:0] ref_mem [256];
  int n_checks = 0;
  int n_err    = 0;
  int both_en  = 0;

  always #5 LSU_clk = ~LSU_clk;

  load_store_unit dut (
    .LSU_clk            (LSU_clk),
    .LSU_rst            (LSU_rst),
    .LSU_req_valid      (LSU_req_valid),
    .LSU_req_ready      (LSU_req_ready),
    .LSU_req_write      (LSU_req_write),
    .LSU_req_size       (LSU_req_size),
    .LSU_req_unsigned   (LSU_req_unsigned),
    .LSU_req_addr       (LSU_req_addr),
    .LSU_req_wdata      (LSU_req_wdata),
    .LSU_rsp_valid      (LSU_rsp_valid),
    .LSU_rsp_rdata      (LSU_rsp_rdata),
    .LSU_rsp_fault      (LSU_rsp_fault),
    .LSU_dmem_address   (LSU_dmem_address),
    .LSU_dmem_wdata     (LSU_dmem_wdata),
    .LSU_dmem_mem_write (LSU_dmem_mem_write),
    .LSU_dmem_mem_read  (LSU_dmem_mem_read),
    .LSU_dmem_rdata     (LSU_dmem_rdata)
  );

  // DMEM model: combinational read, write on clock edge
  assign LSU_dmem_rdata = dmem[LSU_dmem_address];
  always @(posedge LSU_clk) if (LSU_dmem_mem_write) dmem[LSU_dmem_address] <= LSU_dmem_wdata;

  always @(negedge LSU_clk) if (LSU_dmem_mem_read && LSU_dmem_mem_write) both_en++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: treat a word as 4 bytes, index 0 most significant.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd,
                        output logic [31:0] got_rdata, output logic got_fault);
    logic [7:0]  by [4];
    logic [7:0]  nb [4];
    logic [31:0] w, exp_rd, new_w;
    logic        flt, sub_st;
    int          idx, o;
    idx = int'(addr[9:2]);
    o   = int'(addr[1:0]);
    w   = ref_mem[idx];
    by[0] = w[31:24]; by[1] = w[23:16]; by[2] = w[15:8]; by[3] = w[7:0];
    flt = (sz == 2'd3) || (sz == 2'd1 && (o % 2) != 0) || (sz == 2'd2 && o != 0);
`ifdef LSU_RANGE_CHECK_EN
    flt = flt || (addr[31:10] != 0) || (idx >= 11);
`endif
    exp_rd = 32'd0;
    if (sz == 2'd0) begin
      exp_rd = {24'd0, by[o]};
      if (!uns && by[o][7]) exp_rd = exp_rd | 32'hFFFF_FF00;
    end else if (sz == 2'd1 && o <= 2) begin
      exp_rd = {16'd0, by[o], by[o+1]};
      if (!uns && by[o][7]) exp_rd = exp_rd | 32'hFFFF_0000;
    end else exp_rd = w;
    nb = by;
    if (sz == 2'd0) nb[o] = wd[7:0];
    else if (sz == 2'd1 && o <= 2) begin nb[o] = wd[15:8]; nb[o+1] = wd[7:0]; end
    new_w = (sz == 2'd2) ? wd : {nb[0], nb[1], nb[2], nb[3]};
    sub_st = wr && !flt && (sz != 2'd2);

    LSU_req_valid = 1'b1; LSU_req_write = wr; LSU_req_size = sz;
    LSU_req_unsigned = uns; LSU_req_addr = addr; LSU_req_wdata = wd;
    #1;
    chk("ready_idle", 32'(LSU_req_ready), 32'd1);
    chk("acc_rd_en", 32'(LSU_dmem_mem_read), 32'(!flt && (!wr || sub_st)));
    chk("acc_wr_en", 32'(LSU_dmem_mem_write), 32'(!flt && wr && sz == 2'd2));
    if (!flt) chk("acc_addr", 32'(LSU_dmem_address), 32'(idx));
    if (!flt && wr && sz == 2'd2) chk("acc_wdata", LSU_dmem_wdata, wd);
    @(posedge LSU_clk); #1;
    LSU_req_valid = 1'b0;
    if (sub_st) begin
      @(negedge LSU_clk);
      chk("merge_ready", 32'(LSU_req_ready), 32'd0);
      chk("merge_wr_en", 32'(LSU_dmem_mem_write), 32'd1);
      chk("merge_rd_en", 32'(LSU_dmem_mem_read), 32'd0);
      chk("merge_addr", 32'(LSU_dmem_address), 32'(idx));
      chk("merge_wdata", LSU_dmem_wdata, new_w);
      chk("merge_no_rsp", 32'(LSU_rsp_valid), 32'd0);
    end
    @(negedge LSU_clk);
    chk("rsp_valid", 32'(LSU_rsp_valid), 32'd1);
    chk("rsp_fault", 32'(LSU_rsp_fault), 32'(flt));
    chk("rsp_rdata", LSU_rsp_rdata, (!flt && !wr) ? exp_rd : 32'd0);
    if (wr && !flt) ref_mem[idx] = new_w;
    chk("mem_word", dmem[idx], ref_mem[idx]);
    got_rdata = LSU_rsp_rdata;
    got_fault = LSU_rsp_fault;
  endtask

  initial begin
    logic [31:0] r, a, v;
    logic        f;
    LSU_rst = 1'b1; LSU_req_valid = 1'b1; LSU_req_write = 1'b1;
    LSU_req_size = 2'd2; LSU_req_unsigned = 1'b0;
    LSU_req_addr = 32'h0000_0008; LSU_req_wdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 256; i++) begin
      v = $urandom;
      dmem[i] <= v;
      ref_mem[i] = v;
    end
    repeat (3) @(posedge LSU_clk);
    @(negedge LSU_clk);
    chk("rst_ready", 32'(LSU_req_ready), 32'd0);
    chk("rst_rd_en", 32'(LSU_dmem_mem_read), 32'd0);
    chk("rst_wr_en", 32'(LSU_dmem_mem_write), 32'd0);
    chk("rst_rsp_valid", 32'(LSU_rsp_valid), 32'd0);
    chk("rst_rsp_rdata", LSU_rsp_rdata, 32'd0);
    chk("rst_rsp_fault", 32'(LSU_rsp_fault), 32'd0);
    LSU_req_valid = 1'b0; LSU_rst = 1'b0;
    @(negedge LSU_clk);
    chk("mem_untouched_rst", dmem[2], ref_mem[2]);

    // Big-endian sub-word loads
    dmem[2] <= 32'h8899_AABB; ref_mem[2] = 32'h8899_AABB;
    do_req(1'b0, 2'd0, 1'b0, 32'h0A, 32'd0, r, f); chk("lb_0A", r, 32'hFFFF_FFAA);
    do_req(1'b0, 2'd1, 1'b1, 32'h08, 32'd0, r, f); chk("lhu_08", r, 32'h0000_8899);
    do_req(1'b0, 2'd1, 1'b0, 32'h0A, 32'd0, r, f); chk("lh_0A", r, 32'hFFFF_AABB);

    // Byte store read-modify-write
    dmem[2] <= 32'h1122_3344; ref_mem[2] = 32'h1122_3344;
    do_req(1'b1, 2'd0, 1'b0, 32'h09, 32'h0000_00EE, r, f);
    chk("sb_09_word", dmem[2], 32'h11EE_3344);

    // Faults
    do_req(1'b0, 2'd2, 1'b0, 32'h06, 32'd0, r, f); chk("lw_06_fault", 32'(f), 32'd1);
    do_req(1'b0, 2'd3, 1'b0, 32'h10, 32'd0, r, f); chk("size3_fault", 32'(f), 32'd1);

    // Reset while in MERGE aborts the write-back
    v = ref_mem[1];
    LSU_req_valid = 1'b1; LSU_req_write = 1'b1; LSU_req_size = 2'd1;
    LSU_req_unsigned = 1'b0; LSU_req_addr = 32'h04; LSU_req_wdata = 32'h0000_5A5A;
    @(posedge LSU_clk); #1;
    LSU_req_valid = 1'b0;
    @(negedge LSU_clk);
    chk("abort_in_merge", 32'(LSU_dmem_mem_write), 32'd1);
    LSU_rst = 1'b1;
    #1;
    chk("abort_wr_en", 32'(LSU_dmem_mem_write), 32'd0);
    chk("abort_ready", 32'(LSU_req_ready), 32'd0);
    @(negedge LSU_clk);
    LSU_rst = 1'b0;
    chk("abort_no_rsp", 32'(LSU_rsp_valid), 32'd0);
    chk("abort_word1", dmem[1], v);
    do_req(1'b0, 2'd2, 1'b0, 32'h04, 32'd0, r, f); chk("after_abort_lw", r, v);

    // Index 11: range fault only when range checking is built in
    do_req(1'b0, 2'd2, 1'b0, 32'h2C, 32'd0, r, f);
`ifdef LSU_RANGE_CHECK_EN
    chk("lw_2C_range", 32'(f), 32'd1);
`else
    chk("lw_2C_range", 32'(f), 32'd0);
`endif

    // Back-to-back word loads, one per cycle
    for (int i = 0; i < 6; i++) begin
      LSU_req_valid = 1'b1; LSU_req_write = 1'b0; LSU_req_size = 2'd2;
      LSU_req_unsigned = 1'b0; LSU_req_addr = 32'(i * 4);
      #1;
      chk("b2b_ready", 32'(LSU_req_ready), 32'd1);
      chk("b2b_rd_en", 32'(LSU_dmem_mem_read), 32'd1);
      if (i > 0) begin
        chk("b2b_valid", 32'(LSU_rsp_valid), 32'd1);
        chk("b2b_rdata", LSU_rsp_rdata, ref_mem[i-1]);
      end
      @(negedge LSU_clk);
    end
    LSU_req_valid = 1'b0;
    #1;
    chk("b2b_last", LSU_rsp_rdata, ref_mem[5]);
    @(negedge LSU_clk);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      a = 32'($urandom_range(0, 12) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | ($urandom << 10);
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom, r, f);
      if ($urandom_range(0, 3) == 0) begin
        LSU_req_valid = 1'b0;
        @(negedge LSU_clk);
        chk("idle_valid", 32'(LSU_rsp_valid), 32'd0);
        chk("idle_rdata", LSU_rsp_rdata, 32'd0);
        chk("idle_fault", 32'(LSU_rsp_fault), 32'd0);
        chk("idle_rd_en", 32'(LSU_dmem_mem_read), 32'd0);
        chk("idle_wr_en", 32'(LSU_dmem_mem_write), 32'd0);
      end
    end

    for (int i = 0; i < 16; i++) chk("final_mem", dmem[i], ref_mem[i]);
    chk("rd_wr_exclusive", 32'(both_en), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
